// File: rtl/adsr_envelope.sv
// ADSR envelope generator: scales the oscillator sample by an attack/decay/sustain/release
// envelope that is gated by a note signal and advanced on a programmable prescaled tick.
module adsr_envelope #(
  parameter int unsigned resolution_bits = 8,
  parameter int unsigned env_bits        = 8,
  parameter int unsigned tick_width      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       gate,
  input  logic [tick_width-1:0]      tick_div,
  input  logic [env_bits-1:0]        attack_step,
  input  logic [env_bits-1:0]        decay_step,
  input  logic [env_bits-1:0]        sustain_level,
  input  logic [env_bits-1:0]        release_step,
  input  logic [resolution_bits-1:0] wave_in,
  output logic [resolution_bits-1:0] wave_out,
  output logic [env_bits-1:0]        envelope,
  output logic                       active
);

  localparam int unsigned PROD_W = resolution_bits + env_bits;
  localparam logic [env_bits-1:0] ENV_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } state_t;

  state_t                state;
  logic [tick_width-1:0] count;
  logic                  tick;
  logic [env_bits:0]     attack_sum;
  logic [env_bits:0]     decay_floor;
  logic [PROD_W-1:0]     product;

  // A count above a freshly lowered tick_div wraps without producing a tick.
  assign tick = (count == tick_div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (count >= tick_div) begin
      count <= '0;
    end else begin
      count <= count + tick_width'(1);
    end
  end

  // One extra bit so the saturation and floor tests cannot wrap.
  assign attack_sum  = {1'b0, envelope} + {1'b0, attack_step};
  assign decay_floor = {1'b0, sustain_level} + {1'b0, decay_step};

  // Gate changes are handled before tick updates; a gate edge never moves the level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      envelope <= '0;
    end else begin
      case (state)
        IDLE: begin
          envelope <= '0;
          if (gate) state <= ATTACK;
        end
        ATTACK: begin
          if (!gate) begin
            state <= RELEASE;
          end else if (tick) begin
            if (attack_step == '0 || attack_sum >= {1'b0, ENV_MAX}) begin
              envelope <= ENV_MAX;
              state    <= DECAY;
            end else begin
              envelope <= attack_sum[env_bits-1:0];
            end
          end
        end
        DECAY: begin
          if (!gate) begin
            state <= RELEASE;
          end else if (tick) begin
            if (decay_step == '0 || {1'b0, envelope} <= decay_floor) begin
              envelope <= sustain_level;
              state    <= SUSTAIN;
            end else begin
              envelope <= envelope - decay_step;
            end
          end
        end
        SUSTAIN: begin
          if (!gate) begin
            state <= RELEASE;
          end else begin
            envelope <= sustain_level;
          end
        end
        RELEASE: begin
          if (gate) begin
            state <= ATTACK;
          end else if (tick) begin
            if (release_step == '0 || envelope <= release_step) begin
              envelope <= '0;
              state    <= IDLE;
            end else begin
              envelope <= envelope - release_step;
            end
          end
        end
        default: begin
          state    <= IDLE;
          envelope <= '0;
        end
      endcase
    end
  end

  // Full-width unsigned product; keep the top resolution_bits.
  assign product = PROD_W'(wave_in) * PROD_W'(envelope);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wave_out <= '0;
    end else begin
      wave_out <= product[PROD_W-1:env_bits];
    end
  end

  assign active = (state != IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Scoreboard bench for adsr_envelope: a behavioural model predicts every post-edge output,
// a separate monitor pops and compares after each rising edge.
module tb_adsr_envelope;

  localparam int EMAX = 255;
  localparam int P_IDLE = 0, P_ATT = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        gate = 1'b0;
  logic [15:0] tick_div = '0;
  logic [7:0]  attack_step = '0, decay_step = '0, sustain_level = '0, release_step = '0;
  logic [7:0]  wave_in = '0;
  logic [7:0]  wave_out;
  logic [7:0]  envelope;
  logic        active;

  adsr_envelope dut (
    .clk(clk), .reset(reset), .gate(gate), .tick_div(tick_div),
    .attack_step(attack_step), .decay_step(decay_step),
    .sustain_level(sustain_level), .release_step(release_step),
    .wave_in(wave_in), .wave_out(wave_out), .envelope(envelope), .active(active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int env;
    int wout;
    bit act;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Model state and the stimulus settings applied on the next cycle.
  int m_phase = P_IDLE, m_env = 0, m_cnt = 0;
  bit s_rst = 1, s_gate = 0;
  int s_div = 0, s_as = 0, s_ds = 0, s_sus = 0, s_rs = 0, s_win = 0;
  bit s_rand_win = 1;

  task automatic model_step();
    int nphase, nenv, ncnt, nwout;
    bit tk;
    exp_t e;
    if (s_rst) begin
      nphase = P_IDLE; nenv = 0; ncnt = 0; nwout = 0;
    end else begin
      tk     = (m_cnt == s_div);
      ncnt   = (m_cnt >= s_div) ? 0 : m_cnt + 1;
      nwout  = (s_win * m_env) / 256;
      nphase = m_phase;
      nenv   = m_env;
      case (m_phase)
        P_IDLE: begin nenv = 0; if (s_gate) nphase = P_ATT; end
        P_ATT:
          if (!s_gate) nphase = P_REL;
          else if (tk) begin
            if (s_as == 0 || m_env + s_as >= EMAX) begin nenv = EMAX; nphase = P_DEC; end
            else nenv = m_env + s_as;
          end
        P_DEC:
          if (!s_gate) nphase = P_REL;
          else if (tk) begin
            if (s_ds == 0 || m_env <= s_sus + s_ds) begin nenv = s_sus; nphase = P_SUS; end
            else nenv = m_env - s_ds;
          end
        P_SUS:
          if (!s_gate) nphase = P_REL;
          else nenv = s_sus;
        default:
          if (s_gate) nphase = P_ATT;
          else if (tk) begin
            if (s_rs == 0 || m_env <= s_rs) begin nenv = 0; nphase = P_IDLE; end
            else nenv = m_env - s_rs;
          end
      endcase
    end
    m_phase = nphase; m_env = nenv; m_cnt = ncnt;
    e.env = nenv; e.wout = nwout; e.act = (nphase != P_IDLE);
    exp_q.push_back(e);
  endtask

  task automatic drive(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (s_rand_win) s_win = int'($urandom_range(0, 255));
      reset         = s_rst;
      gate          = s_gate;
      tick_div      = 16'(s_div);
      attack_step   = 8'(s_as);
      decay_step    = 8'(s_ds);
      sustain_level = 8'(s_sus);
      release_step  = 8'(s_rs);
      wave_in       = 8'(s_win);
      model_step();
    end
  endtask

  task automatic do_reset();
    s_rst = 1; s_gate = 0; drive(2); s_rst = 0;
  endtask

  // Monitor: every rising edge presents a new output sample.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (envelope !== 8'(e.env)) begin
        n_bad++;
        $display("FAIL envelope: got %0d expected %0d at %0t", envelope, e.env, $time);
      end
      n_cmp++;
      if (wave_out !== 8'(e.wout)) begin
        n_bad++;
        $display("FAIL wave_out: got %0d expected %0d at %0t", wave_out, e.wout, $time);
      end
      n_cmp++;
      if (active !== e.act) begin
        n_bad++;
        $display("FAIL active: got %0b expected %0b at %0t", active, e.act, $time);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with gate high and full-scale input, then release into ATTACK.
    s_rst = 1; s_gate = 1; s_win = 255; s_rand_win = 0; drive(3);
    s_rand_win = 1;
    s_rst = 0; s_div = 0; s_as = 64; s_ds = 32; s_sus = 128; s_rs = 16;
    drive(14);

    // Mid-attack release at level 40, slow tick.
    do_reset();
    s_gate = 1; s_as = 10; s_div = 3; s_rs = 15;
    for (int i = 0; i < 100 && m_env != 40; i++) drive(1);
    s_gate = 0;
    drive(24);

    // Retrigger from RELEASE at 100 and saturate.
    do_reset();
    s_div = 0; s_as = 100; s_ds = 20; s_sus = 60; s_rs = 5; s_gate = 1;
    drive(2);
    s_gate = 0; drive(1);
    s_gate = 1; drive(5);

    // Output scaling at sustain 128 with a toggling input.
    do_reset();
    s_div = 0; s_as = 64; s_ds = 32; s_sus = 128; s_gate = 1;
    drive(12);
    s_rand_win = 0;
    for (int i = 0; i < 8; i++) begin s_win = (i % 2) ? 255 : 0; drive(1); end
    s_rand_win = 1;

    // All-zero steps: jumps straight to each target.
    do_reset();
    s_div = 2; s_as = 0; s_ds = 0; s_rs = 0; s_sus = 50; s_gate = 1;
    drive(10);
    s_gate = 0; drive(6);

    // Randomized traffic with live parameter changes and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) s_gate = ~s_gate;
      if ($urandom_range(0, 49) == 0) s_div = int'($urandom_range(0, 5));
      if ($urandom_range(0, 39) == 0) s_as = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 255));
      if ($urandom_range(0, 39) == 0) s_ds = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 255));
      if ($urandom_range(0, 39) == 0) s_rs = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 255));
      if ($urandom_range(0, 59) == 0) s_sus = ($urandom_range(0, 4) == 0) ? EMAX : int'($urandom_range(0, 255));
      s_rst = ($urandom_range(0, 299) == 0);
      drive(1);
    end
    s_rst = 0;

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
